// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit. Issues in-order word reads to
//               instruction memory, buffers returned words with their PC in a
//               prefetch FIFO, and presents them through a valid/ready
//               handshake. A PC redirect flushes the stale fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemGnt,
  input  logic        iMemRvalid,
  input  logic [31:0] iMemRdata,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic [31:0] oInst,
  output logic [31:0] oPc,
  output logic        oInstValid,
  input  logic        iInstReady
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW:0] c_DEPTH = FIFO_DEPTH[c_CW:0];

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  logic [31:0]       r_pc;        // next request address
  logic [31:0]       r_rsp_pc;    // PC of the oldest live in-flight request
  logic              r_req;
  logic              r_valid;
  logic [c_CW-1:0]   r_inflight;
  logic [c_CW-1:0]   r_discard;
  logic [c_CW-1:0]   r_count;
  logic [c_AW-1:0]   r_rd;
  logic [c_AW-1:0]   r_wr;
  logic [31:0]       r_data [FIFO_DEPTH];
  logic [31:0]       r_pcq  [FIFO_DEPTH];

  logic              w_gnt;
  logic              w_consume;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_redirect_pc;
  state_t            w_state_n;
  logic [c_CW-1:0]   w_inflight_n;
  logic [c_CW-1:0]   w_discard_n;
  logic [c_CW-1:0]   w_count_n;
  logic [c_CW:0]     w_used_n;
  logic              w_req_n;

  // A response only counts when something is outstanding; orphans are ignored.
  assign w_gnt         = r_req & iMemGnt;
  assign w_consume     = iMemRvalid & ((r_inflight != '0) | (r_discard != '0));
  assign w_push        = w_consume & (r_state == ST_FETCH) & ~iRedirect;
  assign w_pop         = r_valid & iInstReady;
  assign w_redirect_pc = iRedirectPc & ~32'h0000_0003;

  // Next-state values for the fetch/flush controller and the credit counters.
  always_comb begin
    w_state_n    = r_state;
    w_inflight_n = r_inflight;
    w_discard_n  = r_discard;
    w_count_n    = r_count;
    if (iRedirect) begin
      // Every outstanding word, including one granted right now, becomes stale.
      w_discard_n  = r_discard + r_inflight + c_CW'(w_gnt) - c_CW'(w_consume);
      w_inflight_n = '0;
      w_count_n    = '0;
      w_state_n    = (w_discard_n != '0) ? ST_FLUSH : ST_FETCH;
    end else if (r_state == ST_FLUSH) begin
      w_discard_n  = r_discard - c_CW'(w_consume);
      w_count_n    = r_count - c_CW'(w_pop);
      w_state_n    = (w_discard_n == '0) ? ST_FETCH : ST_FLUSH;
    end else begin
      w_inflight_n = r_inflight + c_CW'(w_gnt) - c_CW'(w_push);
      w_count_n    = r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
    w_used_n = {1'b0, w_count_n} + {1'b0, w_inflight_n};
    w_req_n  = (w_state_n == ST_FETCH) && (w_used_n < c_DEPTH);
  end

  // Controller state, counters, PCs, FIFO pointers and registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
    end else begin
      r_state    <= w_state_n;
      r_inflight <= w_inflight_n;
      r_discard  <= w_discard_n;
      r_count    <= w_count_n;
      r_req      <= w_req_n;
      r_valid    <= (w_count_n != '0);
      if (iRedirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_gnt) begin
        r_pc <= r_pc + 32'd4;
      end
      if (iRedirect) begin
        r_rsp_pc <= w_redirect_pc;
      end else if (w_push) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (iRedirect) begin
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + c_AW'(1);
        if (w_pop)  r_rd <= r_rd + c_AW'(1);
      end
    end
  end

  // Prefetch FIFO storage: instruction word and its PC.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_pcq[i]  <= '0;
      end
    end else if (w_push) begin
      r_data[r_wr] <= iMemRdata;
      r_pcq[r_wr]  <= r_rsp_pc;
    end
  end

  assign oMemReq    = r_req;
  assign oMemAddr   = r_pc;
  assign oInst      = r_data[r_rd];
  assign oPc        = r_pcq[r_rd];
  assign oInstValid = r_valid;

`ifndef SYNTHESIS
  // Read data with nothing outstanding is a memory-side protocol error.
  a_no_orphan_rsp : assert property (@(posedge iClk) disable iff (iRst)
    iMemRvalid |-> ((r_inflight != '0) || (r_discard != '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch with a memory responder and
//               a queue-based reference of the expected instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .iClk(clk), .iRst(rst),
    .oMemReq(mem_req), .oMemAddr(mem_addr), .iMemGnt(mem_gnt),
    .iMemRvalid(mem_rvalid), .iMemRdata(mem_rdata),
    .iRedirect(redirect), .iRedirectPc(redirect_pc),
    .oInst(inst), .oPc(pc), .oInstValid(inst_valid), .iInstReady(inst_ready)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  req_t        pend[$];      // requests granted, not yet answered (memory order)
  logic [63:0] expq[$];      // expected FIFO contents {pc, inst}
  logic [31:0] m_pc;
  bit          req_ok;
  int          cyc, n_cmp, n_bad;
  int          gnt_pct, rsp_pct, rdy_pct, lat_max;
  bit          want_rst, junk_rsp, f_redir;
  logic [31:0] f_redir_pc;
  logic [31:0] gnt_addr[$];
  int          gnt_cyc[$];
  logic [31:0] pop_pc[$];
  bit          last_gnt, last_rsp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: drive inputs at negedge, score outputs, advance the reference.
  task automatic step();
    bit          rv, g, pp, exp_req;
    int          stale_n;
    req_t        r;
    @(negedge clk);
    rst         = want_rst;
    redirect    = f_redir;
    redirect_pc = f_redir_pc;
    f_redir     = 1'b0;
    mem_gnt     = ($urandom_range(0, 99) < gnt_pct);
    inst_ready  = ($urandom_range(0, 99) < rdy_pct);
    rv = !rst && (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(0, 99) < rsp_pct);
    if (rst && junk_rsp) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end else begin
      mem_rvalid = rv;
      mem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
    end
    #1;
    if (rst) begin
      pend.delete();
      expq.delete();
      m_pc   = RESET_PC;
      req_ok = 1'b0;
    end
    n_cmp++;
    if (inst_valid !== (expq.size() != 0)) begin
      n_bad++;
      $display("FAIL valid cyc %0d: got %b want %b", cyc, inst_valid, expq.size() != 0);
    end
    if (expq.size() != 0) begin
      n_cmp++;
      if ({pc, inst} !== expq[0]) begin
        n_bad++;
        $display("FAIL head cyc %0d: got pc %h inst %h want pc %h inst %h",
                 cyc, pc, inst, expq[0][63:32], expq[0][31:0]);
      end
    end
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    exp_req = req_ok && (stale_n == 0) && ((expq.size() + pend.size()) < FIFO_DEPTH);
    n_cmp++;
    if (mem_req !== exp_req) begin
      n_bad++;
      $display("FAIL req cyc %0d: got %b want %b", cyc, mem_req, exp_req);
    end
    if (exp_req) begin
      n_cmp++;
      if (mem_addr !== m_pc) begin
        n_bad++;
        $display("FAIL addr cyc %0d: got %h want %h", cyc, mem_addr, m_pc);
      end
    end
    g  = !rst && mem_req && mem_gnt;
    pp = !rst && inst_valid && inst_ready;
    last_gnt = g;
    last_rsp = rv;
    if (!rst) begin
      if (pp) begin
        pop_pc.push_back(pc);
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (rv) begin
        r = pend.pop_front();
        if (!r.stale && !redirect) expq.push_back({r.addr, mem_word(r.addr)});
      end
      if (g) begin
        pend.push_back('{addr: m_pc, stale: redirect, due: cyc + $urandom_range(1, lat_max)});
        gnt_addr.push_back(m_pc);
        gnt_cyc.push_back(cyc);
        m_pc = m_pc + 32'd4;
      end
      if (redirect) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        expq.delete();
        m_pc = redirect_pc & ~32'h3;
      end
      req_ok = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    want_rst = 1'b1;
    repeat (2) step();
    want_rst = 1'b0;
    gnt_addr.delete();
    gnt_cyc.delete();
    pop_pc.delete();
  endtask

  task automatic clear_logs();
    gnt_addr.delete();
    gnt_cyc.delete();
    pop_pc.delete();
  endtask

  task automatic test_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100; lat_max = 1;
    want_rst = 1'b1;
    step();
    n_cmp++;
    if ({mem_req, mem_addr, inst, pc, inst_valid} !== {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: got req %b addr %h inst %h pc %h valid %b", mem_req, mem_addr, inst, pc, inst_valid);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100; lat_max = 1;
    repeat (12) step();
    n_cmp++;
    if (gnt_addr.size() < 4 || pop_pc.size() < 4) begin
      n_bad++;
      $display("FAIL seq_count: got %0d grants %0d pops want >=4", gnt_addr.size(), pop_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (gnt_addr[i] !== 32'(i * 4) || gnt_cyc[i] !== gnt_cyc[0] + i) begin
          n_bad++;
          $display("FAIL seq_req%0d: got %h at +%0d want %h at +%0d", i, gnt_addr[i], gnt_cyc[i] - gnt_cyc[0], i * 4, i);
        end
        n_cmp++;
        if (pop_pc[i] !== 32'(i * 4)) begin
          n_bad++;
          $display("FAIL seq_pop%0d: got %h want %h", i, pop_pc[i], i * 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 0; lat_max = 1;
    repeat (6) step();
    held = inst;
    repeat (6) step();
    n_cmp++;
    if (gnt_addr.size() != 4) begin
      n_bad++;
      $display("FAIL bp_grants: got %0d want 4", gnt_addr.size());
    end
    n_cmp++;
    if ({mem_req, inst_valid, inst, pc} !== {1'b0, 1'b1, mem_word(32'h0), 32'h0} || inst !== held) begin
      n_bad++;
      $display("FAIL bp_hold: got req %b valid %b inst %h pc %h want 0 1 %h 0", mem_req, inst_valid, inst, pc, mem_word(32'h0));
    end
    rdy_pct = 100;
    for (int i = 0; i < 50 && pop_pc.size() < 4; i++) step();
    n_cmp++;
    if (pop_pc.size() < 4) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d pops want 4", pop_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (pop_pc[i] !== 32'(i * 4)) begin
          n_bad++;
          $display("FAIL bp_order%0d: got %h want %h", i, pop_pc[i], i * 4);
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 0; lat_max = 1;
    for (int i = 0; i < 20 && gnt_addr.size() < 3; i++) step();
    gnt_pct = 0; rsp_pct = 100;
    step();
    rsp_pct = 0;
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_pre: got valid %b want 1", inst_valid);
    end
    f_redir = 1'b1; f_redir_pc = 32'h0000_0103;
    step();
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_fall: got valid %b want 0", inst_valid);
    end
    clear_logs();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 50 && pop_pc.size() < 1; i++) step();
    n_cmp++;
    if (gnt_addr.size() < 1 || pop_pc.size() < 1 || gnt_addr[0] !== 32'h100 || pop_pc[0] !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_target: got %0d grants %0d pops, want first req and pc 00000100", gnt_addr.size(), pop_pc.size());
    end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 0; lat_max = 1;
    for (int i = 0; i < 20 && gnt_addr.size() < 2; i++) step();
    rsp_pct = 100;
    f_redir = 1'b1; f_redir_pc = 32'h0000_0200;
    step();
    n_cmp++;
    if ({last_gnt, last_rsp, inst_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL coll_setup: got gnt %b rsp %b valid %b want 1 1 0", last_gnt, last_rsp, inst_valid);
    end
    clear_logs();
    rdy_pct = 100;
    for (int i = 0; i < 50 && pop_pc.size() < 2; i++) step();
    n_cmp++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'h200 || pop_pc[1] !== 32'h204 || gnt_addr[0] !== 32'h200) begin
      n_bad++;
      $display("FAIL coll_stream: got %0d pops, want pcs 00000200 00000204", pop_pc.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_pct = 0; rsp_pct = 100; rdy_pct = 100; lat_max = 1;
    f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFFC;
    step();
    gnt_pct = 100;
    for (int i = 0; i < 50 && pop_pc.size() < 2; i++) step();
    n_cmp++;
    if (gnt_addr.size() < 2 || gnt_addr[0] !== 32'hFFFF_FFFC || gnt_addr[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_req: got %0d grants, want FFFFFFFC then 00000000", gnt_addr.size());
    end
    n_cmp++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_pop: got %0d pops, want FFFFFFFC then 00000000", pop_pc.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 0; lat_max = 1;
    for (int i = 0; i < 20 && gnt_addr.size() < 3; i++) step();
    gnt_pct = 0; rsp_pct = 100;
    step();
    want_rst = 1'b1; junk_rsp = 1'b1;
    step();
    n_cmp++;
    if ({mem_req, mem_addr, inst, pc, inst_valid} !== {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid: got req %b addr %h inst %h pc %h valid %b", mem_req, mem_addr, inst, pc, inst_valid);
    end
    step();
    want_rst = 1'b0; junk_rsp = 1'b0;
    clear_logs();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 50 && pop_pc.size() < 1; i++) step();
    n_cmp++;
    if (gnt_addr.size() < 1 || pop_pc.size() < 1 || gnt_addr[0] !== RESET_PC || pop_pc[0] !== RESET_PC) begin
      n_bad++;
      $display("FAIL rst_restart: got %0d grants %0d pops, want restart at %h", gnt_addr.size(), pop_pc.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    gnt_pct = 70; rsp_pct = 60; rdy_pct = 60; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        f_redir    = 1'b1;
        f_redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      step();
    end
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    repeat (40) step();
    n_cmp++;
    if (pop_pc.size() < 300) begin
      n_bad++;
      $display("FAIL rand_progress: got %0d pops want >=300", pop_pc.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    want_rst = 1'b1; junk_rsp = 1'b0; f_redir = 1'b0; f_redir_pc = '0;
    m_pc = RESET_PC; req_ok = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
